// File: rtl/al_load_seq.sv
// al_load_seq: auto-load sequencer. Pulls NTGT configuration words from the
// BPI readback engine. Each word is presented to its target with a one-cycle
// CAPTURE strobe. The sequencer then waits for that target's sticky DONE
// (bounded by a timeout) and clears DONE with CLR_AL_DONE.
// Optional feature macro: AL_ERASED_SKIP_EN. When defined, erased words
// (16'hFFFF) are skipped and reported on the extra SKIPPED output.
module al_load_seq #(
   parameter int NTGT    = 2,
   parameter int TMO_CYC = 4000,
   parameter int TMR     = 0
) (
   input  logic            CLK40,
   input  logic            RST,
   input  logic            START,
   input  logic [15:0]     AL_DATA,
   input  logic            AL_VLD,
   output logic            AL_RD,
   input  logic [NTGT-1:0] TGT_DONE,
   output logic [NTGT-1:0] CAPTURE,
   output logic [11:0]     BPI_AL_REG,
   output logic            CLR_AL_DONE,
   output logic            BUSY,
   output logic            ALL_DONE,
   output logic [NTGT-1:0] TMO_ERR
`ifdef AL_ERASED_SKIP_EN
   ,
   output logic [NTGT-1:0] SKIPPED
`endif
);

   localparam int IW  = (NTGT > 1) ? $clog2(NTGT) : 1;
   localparam int NCP = (TMR != 0) ? 3 : 1;
   // Timeout is taken on the edge where the count would reach TMO_CYC-1.
   // This makes CAPTURE-to-CLR_AL_DONE span exactly TMO_CYC cycles.
   localparam logic [15:0]   TMO_LAST = 16'(TMO_CYC - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(NTGT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_CAPT, S_WAIT, S_CLR, S_NEXT, S_FIN
   } state_t;

   state_t          state_q [NCP];
   logic [IW-1:0]   idx_q   [NCP];
   state_t          state_v, state_d;
   logic [IW-1:0]   idx_v, idx_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            al_rd_q, al_rd_d;
   logic [NTGT-1:0] capture_q, capture_d;
   logic [11:0]     bpi_q, bpi_d;
   logic            clr_q, clr_d;
   logic            busy_q, busy_d;
   logic            all_done_q, all_done_d;
   logic [NTGT-1:0] tmo_q, tmo_d;
   logic [NTGT-1:0] skip_q, skip_d;

   // Majority vote across copies of state and index (pass-through when single copy)
   generate
      if (TMR != 0) begin : g_tmr
         assign state_v = state_t'((state_q[0] & state_q[1]) |
                                   (state_q[0] & state_q[2]) |
                                   (state_q[1] & state_q[2]));
         assign idx_v   = (idx_q[0] & idx_q[1]) | (idx_q[0] & idx_q[2]) |
                          (idx_q[1] & idx_q[2]);
      end else begin : g_single
         assign state_v = state_q[0];
         assign idx_v   = idx_q[0];
      end
   endgenerate

`ifndef AL_ERASED_SKIP_EN
   // Upper data bits only matter for erased-word detection
   logic unused_data;
   assign unused_data = ^AL_DATA[15:12];
`endif

   // Next-state, counter, sticky status and registered-output decode
   always_comb begin
      state_d    = state_v;
      idx_d      = idx_v;
      cnt_d      = cnt_q;
      bpi_d      = bpi_q;
      busy_d     = busy_q;
      all_done_d = all_done_q;
      tmo_d      = tmo_q;
      skip_d     = skip_q;
      case (state_v)
         S_IDLE: if (START) begin
            state_d    = S_REQ;
            idx_d      = '0;
            all_done_d = 1'b0;
            tmo_d      = '0;
            skip_d     = '0;
            busy_d     = 1'b1;
         end
         S_REQ: if (al_rd_q && AL_VLD) begin
`ifdef AL_ERASED_SKIP_EN
            if (AL_DATA == 16'hFFFF) begin
               skip_d[idx_v] = 1'b1;
               state_d       = S_NEXT;
            end else begin
               bpi_d   = AL_DATA[11:0];
               state_d = S_CAPT;
            end
`else
            bpi_d   = AL_DATA[11:0];
            state_d = S_CAPT;
`endif
         end
         S_CAPT: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // DONE has priority over a coincident timeout
            if (TGT_DONE[idx_v]) begin
               state_d = S_CLR;
            end else if (cnt_q == TMO_LAST) begin
               tmo_d[idx_v] = 1'b1;
               state_d      = S_CLR;
            end
         end
         S_CLR:  state_d = S_NEXT;
         S_NEXT: begin
            if (idx_v == IDX_LAST) begin
               state_d = S_FIN;
            end else begin
               idx_d   = idx_v + 1'b1;
               state_d = S_REQ;
            end
         end
         S_FIN: begin
            all_done_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      al_rd_d   = (state_d == S_REQ);
      capture_d = (state_d == S_CAPT) ? (NTGT'(1) << idx_d) : '0;
      clr_d     = (state_d == S_CLR);
   end

   // State copies, counter and registered outputs
   always_ff @(posedge CLK40 or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NCP; i++) begin
            state_q[i] <= S_IDLE;
            idx_q[i]   <= '0;
         end
         cnt_q      <= '0;
         al_rd_q    <= 1'b0;
         capture_q  <= '0;
         bpi_q      <= 12'h000;
         clr_q      <= 1'b0;
         busy_q     <= 1'b0;
         all_done_q <= 1'b0;
         tmo_q      <= '0;
         skip_q     <= '0;
      end else begin
         for (int i = 0; i < NCP; i++) begin
            state_q[i] <= state_d;
            idx_q[i]   <= idx_d;
         end
         cnt_q      <= cnt_d;
         al_rd_q    <= al_rd_d;
         capture_q  <= capture_d;
         bpi_q      <= bpi_d;
         clr_q      <= clr_d;
         busy_q     <= busy_d;
         all_done_q <= all_done_d;
         tmo_q      <= tmo_d;
         skip_q     <= skip_d;
      end
   end

   assign AL_RD       = al_rd_q;
   assign CAPTURE     = capture_q;
   assign BPI_AL_REG  = bpi_q;
   assign CLR_AL_DONE = clr_q;
   assign BUSY        = busy_q;
   assign ALL_DONE    = all_done_q;
   assign TMO_ERR     = tmo_q;
`ifdef AL_ERASED_SKIP_EN
   assign SKIPPED     = skip_q;
`else
   logic unused_skip;
   assign unused_skip = ^skip_q;
`endif

endmodule

// File: doc/al_load_seq.md
Name: al_load_seq

Overview:
- Auto-load sequencer upstream of the comparator-threshold DAC loader and sibling auto-load targets.
- After power-up, it pulls NTGT configuration words from the BPI readback engine, one per target.
- For each word it presents the 12-bit value with a one-cycle CAPTURE strobe, waits for that target's sticky DONE, then clears it with CLR_AL_DONE.
- Reports overall completion and per-target timeout errors to the JTAG status register.

Parameters:
NTGT, 2, number of auto-load targets/words; target 0 = comparator threshold DAC loader; legal 1..8
TMO_CYC, 4000, CLK40 cycles to wait for a target DONE before flagging timeout (100 us); legal 2..65535
TMR, 0, 1 = state register and target index triplicated with majority vote; 0 = single copy

Ports:
CLK40  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-low reset
START  input  1  one-cycle request to begin an auto-load pass
AL_DATA  input  16  word from BPI readback engine; bits [11:0] used
AL_VLD  input  1  AL_DATA valid
AL_RD  output  1  read request to BPI readback engine
TGT_DONE  input  NTGT  sticky DONE from each target loader
CAPTURE  output  NTGT  one-hot, one-cycle load strobe per target
BPI_AL_REG  output  12  value presented to targets; held stable from the CAPTURE cycle until the next accept
CLR_AL_DONE  output  1  one-cycle clear of the addressed target's DONE
BUSY  output  1  high from START accept until the FIN state
ALL_DONE  output  1  sticky; set at end of pass, cleared on next accepted START
TMO_ERR  output  NTGT  sticky per-target timeout flags, cleared on accepted START

Behaviour:
- Reset values: AL_RD=0, CAPTURE=0, BPI_AL_REG=12'h000, CLR_AL_DONE=0, BUSY=0, ALL_DONE=0, TMO_ERR=0; state IDLE; idx=0; timeout counter=0.
- IDLE: on START=1 -> REQ. Same edge: idx<=0, ALL_DONE<=0, TMO_ERR<=0, BUSY<=1.
- START while BUSY=1 is ignored.
- REQ:
  - AL_RD=1 (level).
  - Word accepted on the edge where AL_RD=1 and AL_VLD=1; BPI_AL_REG<=AL_DATA[11:0]; -> CAPT.
  - AL_RD drops the following cycle.
  - AL_VLD while AL_RD=0 is ignored.
- CAPT (1 cycle): CAPTURE[idx]=1, all other bits 0. Timeout counter <=0. -> WAIT.
- WAIT: samples TGT_DONE[idx]; counter increments every cycle.
  - TGT_DONE[idx]=1 -> CLR.
  - Counter reaches TMO_CYC-1 with DONE low -> TMO_ERR[idx]<=1 -> CLR.
  - DONE and timeout on the same cycle: DONE wins; no error is flagged.
  - TGT_DONE bits other than idx are ignored.
- CLR (1 cycle): CLR_AL_DONE=1. -> NEXT.
- NEXT (1 cycle, gives the target's DONE time to clear):
  - If idx==NTGT-1 -> FIN.
  - Else idx<=idx+1 -> REQ.
- FIN (1 cycle): ALL_DONE<=1, BUSY<=0. -> IDLE.
- Minimum latency per word: accept -> CAPTURE 1 cycle; DONE seen -> CLR_AL_DONE 1 cycle; CLR -> next AL_RD 2 cycles.
- Async reset mid-pass: everything returns to reset values immediately. No partial CAPTURE or CLR pulse is emitted after release. A new START is required.
- idx width: clog2(NTGT), minimum 1 bit. Timeout counter width: 16 bits; it does not wrap, since exit occurs at TMO_CYC-1.
- TMR=1: three copies of state and idx, voted every cycle. Outputs are decoded from the voted values. Behaviour is otherwise identical.

Optional Feature:
- Macro AL_ERASED_SKIP_EN.
- Defined:
  - An accepted word equal to 16'hFFFF (erased flash) is skipped. CAPT, WAIT and CLR are bypassed; REQ goes directly to NEXT.
  - No CAPTURE, and BPI_AL_REG keeps its previous value.
  - Extra output SKIPPED[NTGT-1:0] has the bit set sticky, cleared on accepted START.
- Not defined: 16'hFFFF is treated as an ordinary word (loads 12'hFFF); SKIPPED port absent.

Test Plan:
- NTGT=2, START; AL_VLD returns 16'h0123 then 16'h0456 after 3 cycles each; TGT_DONE[n] asserted 700 cycles after CAPTURE[n] and held until CLR_AL_DONE -> CAPTURE=2'b01 with BPI_AL_REG=12'h123, then 2'b10 with 12'h456; ALL_DONE=1, TMO_ERR=0, BUSY=0 after FIN.
- TGT_DONE[1] never asserted -> exactly 4000 cycles from CAPTURE[1] to CLR_AL_DONE; TMO_ERR=2'b10; ALL_DONE=1.
- TGT_DONE[0] rises on the exact cycle the counter hits TMO_CYC-1 -> TMO_ERR[0]=0, CLR_AL_DONE next cycle.
- Second START pulse during WAIT -> ignored; no extra AL_RD or CAPTURE; pass completes normally.
- RST low during WAIT of target 1, then released -> all outputs at reset values; no CAPTURE or CLR after release until a new START.
- AL_ERASED_SKIP_EN defined, word0=16'hFFFF, word1=16'h0ABC -> no CAPTURE[0], SKIPPED=2'b01, CAPTURE[1] with 12'hABC. Undefined: CAPTURE[0] with 12'hFFF.
